// File: rtl/control_unit_mc_pkg.sv
// Shared types for the multicycle control unit.
//   state_t  - sequencer state encoding
//   opcode_t - instruction opcode field (legal values 0..7; 8..15 are illegal)
//   ALU_*    - ALU function select codes driven on alu_s_o
package control_unit_mc_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5,
        OP_JMPZ  = 4'd6,
        OP_JMP   = 4'd7
    } opcode_t;

    localparam logic [3:0] ALU_PASS = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;

endpackage

// File: rtl/control_unit_mc_mem_wait_timer.sv
// Data-memory wait timer.
// Counts cycles spent in a memory-access state and flags expiry when the
// WAIT_MAX-th cycle in that state still has no ready from memory.
//   clk_i     - clock
//   rst_ni    - asynchronous active-low reset
//   clear_i   - restart the count (asserted the cycle before a memory state)
//   en_i      - currently in a memory-access state
//   d_rdy_i   - data memory ready
//   expired_o - WAIT_MAX-th cycle reached with d_rdy_i low
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    input  logic d_rdy_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

    // cnt_q holds the zero-based index of the current cycle in the memory state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_cycle;

    assign last_cycle = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !last_cycle) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Ready on the final cycle wins over the timeout.
    assign expired_o = en_i && last_cycle && !d_rdy_i;

endmodule

// File: rtl/control_unit_mc.sv
// Multicycle control unit: sequences fetch/decode/execute of
// NOOP/STORE/LOAD/ADD/SUB/HALT/JMPZ/JMP with memory-ready timeout and
// a sticky fault flag. All strobes are Moore-decoded from state and IR.
//
// state    | meaning
// ---------+-----------------------------------------------
// INIT     | clear PC after reset
// FETCH    | load IR, increment PC
// DECODE   | select execute state from opcode
// NOOP     | idle cycle (also untaken JMPZ)
// LOAD_A   | data read request, wait for ready
// LOAD_B   | write memory data into register file
// STORE    | data write request, wait for ready
// ADD/SUB  | ALU operation, capture Z
// JUMP     | PC-relative load
// HALT     | stopped until reset (fault shows why, if set)
//
// Ports: clk_i, rst_ni; ir_i, d_rdy_i, alu_z_i in;
//        PC strobes, data-memory request/address, register-file
//        addresses/enables, ALU select, halted_o, fault_o out.
module control_unit_mc
    import control_unit_mc_pkg::*;
#(
    parameter int RF_ADDR_W = 4,
    parameter int WAIT_MAX  = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [4+3*RF_ADDR_W-1:0] ir_i,
    input  logic                     d_rdy_i,
    input  logic                     alu_z_i,
    output logic                     pc_clr_o,
    output logic                     pr_id_o,
    output logic                     pc_ic_o,
    output logic                     pc_ld_o,
    output logic [2*RF_ADDR_W-1:0]   pc_ofs_o,
    output logic [2*RF_ADDR_W-1:0]   d_addr_o,
    output logic                     d_rd_o,
    output logic                     d_wr_o,
    output logic                     rf_s_o,
    output logic                     rf_w_en_o,
    output logic [RF_ADDR_W-1:0]     rf_a_addr_o,
    output logic [RF_ADDR_W-1:0]     rf_b_addr_o,
    output logic [RF_ADDR_W-1:0]     rf_w_addr_o,
    output logic [3:0]               alu_s_o,
    output logic                     halted_o,
    output logic                     fault_o
);

    localparam int R    = RF_ADDR_W;
    localparam int IR_W = 4 + 3 * R;

    state_t         state_q, state_d;
    logic           z_q, z_d;
    logic           fault_q, fault_d;
    opcode_t        opcode;
    logic [R-1:0]   f2, f1, f0;
    logic           wait_en, wait_clr, wait_expired;

    assign opcode = opcode_t'(ir_i[IR_W-1:3*R]);
    assign f2     = ir_i[3*R-1:2*R];
    assign f1     = ir_i[2*R-1:R];
    assign f0     = ir_i[R-1:0];

    // DECODE is the only path into a memory state, so clearing there
    // restarts the count on every entry.
    assign wait_clr = (state_q == S_DECODE);
    assign wait_en  = (state_q == S_LOAD_A) || (state_q == S_STORE);

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (wait_clr),
        .en_i      (wait_en),
        .d_rdy_i   (d_rdy_i),
        .expired_o (wait_expired)
    );

    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        fault_d = fault_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_NOOP:  state_d = S_NOOP;
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    OP_JMPZ:  state_d = z_q ? S_JUMP : S_NOOP;
                    OP_JMP:   state_d = S_JUMP;
                    default: begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                endcase
            end
            S_NOOP:   state_d = S_FETCH;
            S_LOAD_A: begin
                if (d_rdy_i) begin
                    state_d = S_LOAD_B;
                end else if (wait_expired) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_LOAD_B: state_d = S_FETCH;
            S_STORE: begin
                if (d_rdy_i) begin
                    state_d = S_FETCH;
                end else if (wait_expired) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end
            end
            S_ADD, S_SUB: begin
                z_d     = alu_z_i;
                state_d = S_FETCH;
            end
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_INIT;
            z_q     <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        pc_clr_o    = 1'b0;
        pr_id_o     = 1'b0;
        pc_ic_o     = 1'b0;
        pc_ld_o     = 1'b0;
        pc_ofs_o    = '0;
        d_addr_o    = '0;
        d_rd_o      = 1'b0;
        d_wr_o      = 1'b0;
        rf_s_o      = 1'b0;
        rf_w_en_o   = 1'b0;
        rf_a_addr_o = '0;
        rf_b_addr_o = '0;
        rf_w_addr_o = '0;
        alu_s_o     = ALU_PASS;
        halted_o    = 1'b0;
        case (state_q)
            S_INIT:  pc_clr_o = 1'b1;
            S_FETCH: begin
                pr_id_o = 1'b1;
                pc_ic_o = 1'b1;
            end
            S_LOAD_A: begin
                d_addr_o    = {f2, f1};
                d_rd_o      = 1'b1;
                rf_w_addr_o = f0;
                rf_s_o      = 1'b1;
            end
            S_LOAD_B: begin
                d_addr_o    = {f2, f1};
                rf_w_addr_o = f0;
                rf_s_o      = 1'b1;
                rf_w_en_o   = 1'b1;
            end
            S_STORE: begin
                d_addr_o    = {f1, f0};
                rf_a_addr_o = f2;
                d_wr_o      = 1'b1;
            end
            S_ADD, S_SUB: begin
                rf_a_addr_o = f2;
                rf_b_addr_o = f1;
                rf_w_addr_o = f0;
                rf_w_en_o   = 1'b1;
                alu_s_o     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            S_JUMP: begin
                pc_ld_o  = 1'b1;
                pc_ofs_o = {f1, f0};
            end
            S_HALT:  halted_o = 1'b1;
            default: ;
        endcase
    end

    assign fault_o = fault_q;

endmodule

// File: doc/control_unit_mc.md
# control_unit_mc

Parametrised multicycle control unit for the 16-bit processor family; the successor to the fixed-width fetch/decode/execute sequencer. It sequences fetch, decode and execute of NOOP/STORE/LOAD/ADD/SUB/HALT and adds:
- a data-memory ready handshake with timeout;
- a Z-flag conditional and unconditional PC-relative jump;
- sticky fault reporting.

It sits between the instruction register/PC and the register-file/ALU/data-memory datapath.

## Interface
- RF_ADDR_W, 4, register-file address width R. IR_W = 4+3R and D_ADDR_W = 2R are localparams (defaults 16 and 8).
- WAIT_MAX, 15, maximum cycles spent waiting for D_RDY in one memory state (≥1).
- Clock  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- IR  in  IR_W  instruction register contents. Valid from DECODE until the next FETCH.
- D_RDY  in  1  data memory has completed the current read or write.
- ALU_Z  in  1  datapath ALU result is zero (combinational, same cycle).
- PC_CLR, PR_ID, PC_IC, PC_LD  out  1 each  PC clear, IR load, PC increment, PC load-relative.
- PC_OFS  out  2R  signed jump offset.
- D_ADDR  out  2R  data address.
- D_RD, D_WR  out  1 each  data read and write request.
- RF_S  out  1  write-data select (1 = memory, 0 = ALU).
- RF_W_EN  out  1  register-file write enable.
- RF_A_ADDR, RF_B_ADDR, RF_W_ADDR  out  R each  register-file read and write addresses.
- ALU_S  out  4  ALU function: 0 pass, 1 add, 2 sub.
- Halted, Fault  out  1 each  in HALT state; sticky error flag.

## Operation
- Field layout:
  - opcode = IR[IR_W-1:3R]
  - F2 = IR[3R-1:2R]
  - F1 = IR[2R-1:R]
  - F0 = IR[R-1:0]
- Opcodes: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6 JMPZ, 7 JMP, 8-15 illegal.
- States: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, JUMP, HALT.
- Outputs are Moore-decoded from the state register and IR. Every output not listed for a state is 0.
- INIT: PC_CLR=1. Next state FETCH.
- FETCH: PR_ID=1, PC_IC=1. Next state DECODE.
- DECODE: no strobes. Next state by opcode:
  - 0 → NOOP
  - 1 → STORE
  - 2 → LOAD_A
  - 3 → ADD
  - 4 → SUB
  - 5 → HALT
  - 6 → JUMP if the Z register is 1, else NOOP
  - 7 → JUMP
  - 8-15 → HALT with Fault set
- NOOP → FETCH.
- LOAD_A: D_ADDR={F2,F1}, D_RD=1, RF_W_ADDR=F0, RF_S=1. Stays until D_RDY=1, then LOAD_B.
- LOAD_B: same addresses, RF_S=1, RF_W_EN=1. Next state FETCH.
- STORE: D_ADDR={F1,F0}, RF_A_ADDR=F2, D_WR=1. Stays until D_RDY=1, then FETCH.
- ADD: RF_A_ADDR=F2, RF_B_ADDR=F1, RF_W_ADDR=F0, ALU_S=1, RF_W_EN=1. Z register ← ALU_Z at the end of the cycle. Next state FETCH.
- SUB: as ADD but ALU_S=2.
- JUMP: PC_LD=1, PC_OFS={F1,F0}, interpreted as two's complement. Next state FETCH.
- HALT: Halted=1. Stays in HALT until Reset_n is asserted (low).
- Timeout:
  - The wait counter clears on entry to LOAD_A or STORE.
  - If D_RDY=0 on the WAIT_MAX-th cycle in that state, the next state is HALT and Fault is set.
  - D_RDY=1 on that same cycle wins: normal transition, no fault.
- Fault is sticky until reset. The Z register is cleared only by reset.

## Timing
- Reset (Reset_n=0, asynchronous):
  - state=INIT, Z=0, Fault=0, wait counter=0.
  - Outputs: PC_CLR=1, all other outputs 0.
- Cycles per instruction, from FETCH:
  - NOOP 3; ADD/SUB 3; JMP and taken JMPZ 3; untaken JMPZ 3.
  - LOAD 4+w; STORE 3+w, where w = number of D_RDY=0 cycles (0 ≤ w < WAIT_MAX).
- D_RD/D_WR remain asserted, with a stable address, every cycle until D_RDY is sampled high. Memory commits a write on that cycle.
- A JMPZ immediately after ADD/SUB sees that instruction's Z.
- A Reset_n assertion mid-wait or mid-jump abandons the instruction immediately. No strobe is asserted after reset except PC_CLR.

## Structure
- Package control_unit_mc_pkg holds:
  - state_t enum;
  - opcode_t enum (values as listed);
  - ALU_S constants ALU_PASS, ALU_ADD, ALU_SUB.
- Sub-module mem_wait_timer, parametrised by WAIT_MAX:
  - inputs: clear, count enable, D_RDY;
  - output: expired.
- The top level holds the state register, Z register, Fault register and output decode.

## Test plan
- Reset_n low mid-LOAD_A, then released → PC_CLR=1 during reset; one INIT cycle, then FETCH with PR_ID=1 and PC_IC=1.
- IR=16'h3A95 (ADD), ALU_Z=1 → ADD state: RF_A=A, RF_B=9, RF_W=5, ALU_S=1, RF_W_EN=1. A following IR=16'h60FE (JMPZ) → JUMP with PC_LD=1, PC_OFS=8'hFE.
- IR=16'h2A95 (LOAD), D_RDY low for 3 cycles → D_RD=1 with D_ADDR=A9 for 4 cycles; then LOAD_B: RF_W_EN=1, RF_S=1, RF_W_ADDR=5.
- IR=16'h1A95 (STORE), D_RDY held low → D_WR=1, D_ADDR=95, RF_A=A for exactly 15 cycles; then HALT with Halted=1, Fault=1.
- IR=16'h9000 → HALT with Fault=1. IR=16'h5000 → HALT with Fault=0. Both stay halted with IR changing until reset.
- ADD with ALU_Z=0, then JMPZ → NOOP path, PC_LD never asserted. IR=16'h7080 → PC_LD=1, PC_OFS=8'h80 (−128).
